// File: rtl/alu_pkg.sv
// Shared ALU lane definitions: control codes, widths, flag bit positions and the queued op record.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;
    localparam int DATA_W     = 32;
    localparam int SHAMT_W    = 5;
    localparam int FLAGS_W    = 3;
    localparam int TAG_MAX_W  = 8;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

    localparam int FLAG_COUT = 2;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_ZE   = 0;

    // Tag field is sized for the widest lane; narrower lanes zero-extend on entry.
    typedef struct packed {
        logic [ALU_CTRL_W-1:0]   ctrl;
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic [SHAMT_W-1:0]      shamt;
        logic [TAG_MAX_W-1:0]    tag;
    } alu_op_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Dispatch-side and writeback-side handshake bundle of one ALU issue lane.
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int TAG_W = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ALU_CTRL_W-1:0]    in_ctrl;
    logic [DATA_W-1:0]        in_a;
    logic [DATA_W-1:0]        in_b;
    logic [SHAMT_W-1:0]       in_shamt;
    logic [TAG_W-1:0]         in_tag;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [DATA_W-1:0]        wb_result;
    logic [FLAGS_W-1:0]       wb_flags;
    logic [TAG_W-1:0]         wb_tag;

    modport master (
        output in_valid, in_ctrl, in_a, in_b, in_shamt, in_tag, wb_ready,
        input  in_ready, wb_valid, wb_result, wb_flags, wb_tag
    );

    modport slave (
        input  in_valid, in_ctrl, in_a, in_b, in_shamt, in_tag, wb_ready,
        output in_ready, wb_valid, wb_result, wb_flags, wb_tag
    );

endinterface

// File: rtl/alu_op_fifo.sv
// In-order circular buffer of decoded ALU ops with an occupancy count; flush squashes all entries.
module alu_op_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU lane issue queue plus registered writeback slot; define ALU_ISSUE_BYPASS_EN to let an op
// arriving at an empty queue go straight to the ALU in the same cycle.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    alu_issue_stage_if.slave       io,
    output logic [ALU_CTRL_W-1:0]  alu_ctrl,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [SHAMT_W-1:0]     alu_shamt,
    input  logic [DATA_W-1:0]      alu_r,
    input  logic                   alu_cout,
    input  logic                   alu_ovf,
    input  logic                   alu_ze
);
    alu_op_t              in_op_p0;
    alu_op_t              head_op_p0;
    alu_op_t              issue_op_p0;
    logic                 full;
    logic                 empty;
    logic                 enq;
    logic                 slot_free;
    logic                 issue_q;
    logic                 bypass;
    logic                 issue_any;
    logic                 push;
    logic [FLAGS_W-1:0]   flags_p0;
    logic                 unused_tag_bits;

    logic                 wb_vld_p1;
    logic [DATA_W-1:0]    wb_result_p1;
    logic [FLAGS_W-1:0]   wb_flags_p1;
    logic [TAG_W-1:0]     wb_tag_p1;

    assign in_op_p0 = '{ctrl:  io.in_ctrl,
                        a:     io.in_a,
                        b:     io.in_b,
                        shamt: io.in_shamt,
                        tag:   TAG_MAX_W'(io.in_tag)};

    // No credit for a same-cycle issue: readiness depends on registered occupancy only.
    assign io.in_ready = ~full;
    assign enq         = io.in_valid & ~full;
    assign slot_free   = ~wb_vld_p1 | io.wb_ready;
    assign issue_q     = ~empty & slot_free;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass = empty & enq & slot_free;
`else
    assign bypass = 1'b0;
`endif

    assign issue_any = issue_q | bypass;
    assign push      = enq & ~bypass;

    alu_op_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (alu_op_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (issue_q),
        .din   (in_op_p0),
        .head  (head_op_p0),
        .full  (full),
        .empty (empty)
    );

    // Stage p0: select the op presented to the combinational ALU.
    always_comb begin
        issue_op_p0 = head_op_p0;
        if (empty)  issue_op_p0 = '0;
        if (bypass) issue_op_p0 = in_op_p0;
    end

    assign alu_ctrl  = issue_op_p0.ctrl;
    assign alu_a     = issue_op_p0.a;
    assign alu_b     = issue_op_p0.b;
    assign alu_shamt = issue_op_p0.shamt;

    assign unused_tag_bits = ^issue_op_p0.tag;

    always_comb begin
        flags_p0            = '0;
        flags_p0[FLAG_COUT] = alu_cout;
        flags_p0[FLAG_OVF]  = alu_ovf;
        flags_p0[FLAG_ZE]   = alu_ze;
    end

    // Stage p1: writeback slot; data holds its last value once the consumer drains it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_vld_p1    <= 1'b0;
            wb_result_p1 <= '0;
            wb_flags_p1  <= '0;
            wb_tag_p1    <= '0;
        end else if (flush) begin
            wb_vld_p1    <= 1'b0;
        end else if (issue_any) begin
            wb_vld_p1    <= 1'b1;
            wb_result_p1 <= alu_r;
            wb_flags_p1  <= flags_p0;
            wb_tag_p1    <= issue_op_p0.tag[TAG_W-1:0];
        end else if (io.wb_ready) begin
            wb_vld_p1    <= 1'b0;
        end
    end

    assign io.wb_valid  = wb_vld_p1;
    assign io.wb_result = wb_result_p1;
    assign io.wb_flags  = wb_flags_p1;
    assign io.wb_tag    = wb_tag_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with an adder stub standing in for the ALU.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  tag;
        logic [31:0] exp_r;
        logic [2:0]  exp_f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_r;
    logic        alu_cout;
    logic        alu_ovf;
    logic        alu_ze;
    logic [32:0] sum;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_stage_if #(.TAG_W(TAG_W)) bus();

    alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .io        (bus),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_shamt (alu_shamt),
        .alu_r     (alu_r),
        .alu_cout  (alu_cout),
        .alu_ovf   (alu_ovf),
        .alu_ze    (alu_ze)
    );

    always #5 clk = ~clk;

    assign sum      = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_r    = sum[31:0];
    assign alu_cout = sum[32];
    assign alu_ze   = (sum[31:0] == 32'd0);
    assign alu_ovf  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [4:0] t);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_shamt = sh;
        bus.in_tag   = t;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    vec_t vecs[6];
    logic [4:0]  exp_tag[$];
    logic [31:0] exp_res[$];

    initial begin
        int lat;
        int sent;
        int got;
        int first_cyc;
        int last_cyc;
        int seen;

        vecs[0] = '{ALU_ADD, 32'd12,         32'd6,          5'd1,  5'd3,  32'd18,         3'b000};
        vecs[1] = '{ALU_ADD, 32'hFFFFFFFF,   32'd1,          5'd2,  5'd7,  32'd0,          3'b101};
        vecs[2] = '{ALU_SUB, 32'h7FFFFFFF,   32'd1,          5'd3,  5'd11, 32'h80000000,   3'b010};
        vecs[3] = '{ALU_SLT, 32'h80000000,   32'h80000000,   5'd4,  5'd31, 32'd0,          3'b111};
        vecs[4] = '{ALU_XOR, 32'd0,          32'd0,          5'd31, 5'd0,  32'd0,          3'b001};
        vecs[5] = '{ALU_OR,  32'hFFFFFFFE,   32'd1,          5'd17, 5'd19, 32'hFFFFFFFF,   3'b000};

        // Reset held two cycles with an op offered
        rst_n = 1'b0;
        flush = 1'b0;
        bus.wb_ready = 1'b1;
        drive(1'b1, ALU_ADD, 32'd77, 32'd1, 5'd0, 5'd9);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        #1;
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_wb_result", bus.wb_result, 0);
        check("rst_wb_flags", bus.wb_flags, 0);
        check("rst_wb_tag", bus.wb_tag, 0);
        step();
        check("rst_no_ghost", bus.wb_valid, 0);

        // Single ops from the table
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].shamt, vecs[i].tag);
            #1;
`ifdef ALU_ISSUE_BYPASS_EN
            check("vec_alu_ctrl", alu_ctrl, vecs[i].ctrl);
            check("vec_alu_shamt", alu_shamt, vecs[i].shamt);
`endif
            step();
            idle();
            #1;
`ifndef ALU_ISSUE_BYPASS_EN
            check("vec_alu_ctrl", alu_ctrl, vecs[i].ctrl);
            check("vec_alu_shamt", alu_shamt, vecs[i].shamt);
`endif
            lat = 0;
            while (!bus.wb_valid && lat < 8) begin
                step();
                lat++;
            end
            check("vec_latency", lat, LAT);
            check("vec_result", bus.wb_result, vecs[i].exp_r);
            check("vec_flags", bus.wb_flags, vecs[i].exp_f);
            check("vec_tag", bus.wb_tag, vecs[i].tag);
            step();
            check("vec_wb_drop", bus.wb_valid, 0);
            check("vec_hold_result", bus.wb_result, vecs[i].exp_r);
        end

        // Fill under backpressure, then drain in order
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ALU_ADD, 32'(k), 32'd100, 5'd0, 5'(k));
            #1;
            check("fill_in_ready", bus.in_ready, 1);
            step();
        end
        idle();
        check("full_in_ready", bus.in_ready, 0);
        check("full_wb_valid", bus.wb_valid, 1);
        check("full_wb_tag", bus.wb_tag, 0);
        step();
        check("full_hold_ready", bus.in_ready, 0);
        check("full_hold_tag", bus.wb_tag, 0);
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("drain_valid", bus.wb_valid, 1);
            check("drain_tag", bus.wb_tag, 32'(k));
            check("drain_result", bus.wb_result, 32'(100 + k));
            step();
        end
        check("drain_empty", bus.wb_valid, 0);
        check("drain_in_ready", bus.in_ready, 1);

        // Back-to-back stream wrapping the pointers
        sent = 0;
        got = 0;
        first_cyc = -1;
        last_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            if (sent < 10)
                drive(1'b1, ALU_ADD, 32'(sent * 7 + 1), 32'hFFFFFFF0 + 32'(sent), 5'd0, 5'(sent + 10));
            else
                idle();
            #1;
            if (bus.wb_valid) begin
                check("stream_expected", 32'(exp_tag.size() != 0), 1);
                if (exp_tag.size() != 0) begin
                    check("stream_tag", bus.wb_tag, exp_tag.pop_front());
                    check("stream_result", bus.wb_result, exp_res.pop_front());
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_tag.push_back(bus.in_tag);
                exp_res.push_back(bus.in_a + bus.in_b);
                sent++;
            end
            step();
        end
        idle();
        check("stream_count", got, 10);
        check("stream_rate", last_cyc - first_cyc, 9);

        // Flush with three queued, one in the slot, and an op offered
        step();
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ALU_ADD, 32'(40 + k), 32'd1, 5'd0, 5'(24 + k));
            step();
        end
        idle();
        check("preflush_wb_valid", bus.wb_valid, 1);
        check("preflush_wb_tag", bus.wb_tag, 24);
        check("preflush_in_ready", bus.in_ready, 1);
        drive(1'b1, ALU_ADD, 32'd55, 32'd1, 5'd0, 5'd30);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        #1;
        check("flush_wb_valid", bus.wb_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_alu_a", alu_a, 0);
        bus.wb_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            step();
            if (bus.wb_valid) seen++;
        end
        check("flush_no_ghost", seen, 0);
        drive(1'b1, ALU_ADD, 32'd5, 32'd5, 5'd0, 5'd21);
        step();
        idle();
        lat = 0;
        while (!bus.wb_valid && lat < 8) begin
            step();
            lat++;
        end
        check("post_flush_latency", lat, LAT);
        check("post_flush_result", bus.wb_result, 10);
        check("post_flush_tag", bus.wb_tag, 21);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
